// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, state codes and pixel type for the frame-buffer scheduler
package fb_pkg;

  localparam int FB_H_ACTIVE = 400;
  localparam int FB_V_ACTIVE = 300;
  localparam int FB_ADDR_W   = 17;
  localparam int FB_PIX_W    = 6;
  localparam int FB_PIXELS   = FB_H_ACTIVE * FB_V_ACTIVE;

  typedef logic [1:0] fb_state_t;

  localparam fb_state_t ST_IDLE   = 2'd0;
  localparam fb_state_t ST_ACTIVE = 2'd1;
  localparam fb_state_t ST_VBLANK = 2'd2;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } fb_pixel_t;

endpackage

// File: rtl/fb_scan_addr_gen.sv
// rtl/fb_scan_addr_gen.sv - scan-out FSM and saturating read address; FB_VBLANK_ONLY_EN limits host window to blanking
module fb_scan_addr_gen
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = FB_H_ACTIVE,
  parameter int V_ACTIVE = FB_V_ACTIVE,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [10:0]       count_rgb,
  input  logic [9:0]        reset_count_rgb,
  output logic              rd_issue,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fstart,
  output logic              host_window
);

  localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              active;

  // Decode the counters, decide whether this cycle is a display read and which address it uses
  always_comb begin
    active   = pix_en && (count_rgb < H_LIM) && (reset_count_rgb < V_LIM);
    fstart   = pix_en && (count_rgb == '0) && (reset_count_rgb == '0);
    // A frame start always opens scan-out so the first read of a frame is address 0
    rd_issue = active && (fstart || (state_q == ST_ACTIVE));
    rd_addr  = fstart ? '0 : rd_addr_q;
  end

  // Next read address: step past the issued one, pinned at the last pixel so it never wraps mid-frame
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (rd_issue) begin
      if (rd_addr >= LAST_ADDR) begin
        rd_addr_d = LAST_ADDR;
      end else begin
        rd_addr_d = rd_addr + 1'b1;
      end
    end
  end

  // Frame tracking, advanced only on pixel strobes
  always_comb begin
    state_d = state_q;
    if (pix_en) begin
      case (state_q)
        ST_IDLE: begin
          if (fstart) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!fstart && (reset_count_rgb >= V_LIM)) state_d = ST_VBLANK;
        end
        ST_VBLANK: begin
          if (fstart) state_d = ST_ACTIVE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef FB_VBLANK_ONLY_EN
  // Host may write only while the image is not being scanned (tear-free updates)
  always_comb begin
    host_window = (state_q == ST_IDLE) || (state_q == ST_VBLANK);
  end
`else
  // Host may write in any cycle the display does not claim the RAM
  always_comb begin
    host_window = 1'b1;
  end
`endif

  // State and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule

// File: rtl/fb_access_scheduler.sv
// rtl/fb_access_scheduler.sv - arbitrates pixel RAM between VGA scan-out and a host writer, drives colour pins
module fb_access_scheduler
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = FB_H_ACTIVE,
  parameter int V_ACTIVE = FB_V_ACTIVE,
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int PIX_W    = FB_PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [10:0]       count_rgb,
  input  logic [9:0]        reset_count_rgb,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [1:0]        red_1,
  output logic [1:0]        green_1,
  output logic [1:0]        blue_1,
  output logic              frame_start,
  output logic              wr_err
);

  localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

  logic              rd_issue;
  logic [ADDR_W-1:0] rd_addr;
  logic              fstart;
  logic              host_window;
  logic              wr_fire;
  logic              wr_in_range;

  logic              rd_vld_q, rd_vld_d;
  logic              pe_q, pe_d;
  fb_pixel_t         pix_q, pix_d;
  logic              frame_start_q, frame_start_d;
  logic              wr_err_q, wr_err_d;

  fb_scan_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W)
  ) u_scan (
    .clk             (clk),
    .rst_n           (rst_n),
    .pix_en          (pix_en),
    .count_rgb       (count_rgb),
    .reset_count_rgb (reset_count_rgb),
    .rd_issue        (rd_issue),
    .rd_addr         (rd_addr),
    .fstart          (fstart),
    .host_window     (host_window)
  );

  // Grant: display reads always win; out-of-range host writes are accepted but never reach the RAM
  always_comb begin
    wr_ready    = !rd_issue && host_window;
    wr_fire     = wr_valid && wr_ready;
    wr_in_range = ({1'b0, wr_addr} < PIX_LIMIT);
    ram_addr    = rd_issue ? rd_addr : wr_addr;
    ram_we      = wr_fire && wr_in_range;
    ram_wdata   = wr_data;
  end

  // Output pipeline: stage 1 remembers the strobe and read, stage 2 loads RAM data or black
  always_comb begin
    rd_vld_d      = rd_issue;
    pe_d          = pix_en;
    pix_d         = pix_q;
    if (pe_q) begin
      pix_d = rd_vld_q ? fb_pixel_t'(ram_rdata) : '0;
    end
    frame_start_d = fstart;
    wr_err_d      = wr_err_q || (wr_fire && !wr_in_range);
  end

  // Pipeline and status registers; reset drops any read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q      <= 1'b0;
      pe_q          <= 1'b0;
      pix_q         <= '0;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      rd_vld_q      <= rd_vld_d;
      pe_q          <= pe_d;
      pix_q         <= pix_d;
      frame_start_q <= frame_start_d;
      wr_err_q      <= wr_err_d;
    end
  end

  assign red_1       = pix_q.r;
  assign green_1     = pix_q.g;
  assign blue_1      = pix_q.b;
  assign frame_start = frame_start_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_fb_access_scheduler.sv
// tb/tb_fb_access_scheduler.sv - randomized self-checking bench for fb_access_scheduler against a frame-level model
module tb_fb_access_scheduler;

  localparam int H  = 20;
  localparam int V  = 12;
  localparam int P  = H * V;
  localparam int HT = H + 4;
  localparam int VT = V + 3;
  localparam int AW = 17;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic [10:0]   count_rgb = '0;
  logic [9:0]    reset_count_rgb = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_data = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [PW-1:0] ram_wdata;
  logic [PW-1:0] ram_rdata = '0;
  logic [1:0]    red_1, green_1, blue_1;
  logic          frame_start;
  logic          wr_err;

  fb_access_scheduler #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .PIX_W    (PW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pix_en          (pix_en),
    .count_rgb       (count_rgb),
    .reset_count_rgb (reset_count_rgb),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .red_1           (red_1),
    .green_1         (green_1),
    .blue_1          (blue_1),
    .frame_start     (frame_start),
    .wr_err          (wr_err)
  );

  always #5 clk = ~clk;

  // Physical single-port RAM with one-cycle read latency, preloaded with i mod 64
  logic [PW-1:0] ram [P];
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < P; i++) ram[i] <= PW'(i % 64);
      ram_loaded <= 1'b1;
    end else if (ram_we && ram_addr < P) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= (ram_addr < P) ? ram[ram_addr] : '0;
  end

  // Reference model state
  int  ref_mem [P];
  bit  scanning;
  int  k;
  bit  p1_pe, p1_rd;
  int  p1_pix;
  int  exp_col;
  bit  exp_fs, exp_err;
  bit  host_rand, oor_ok;
  int  n_checks, n_fail;
  int  obs_addr, obs_ready, obs_we, pix_addr, fs_count;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    scanning = 0; k = 0;
    p1_pe = 0; p1_rd = 0; p1_pix = 0;
    exp_col = 0; exp_fs = 0; exp_err = 0;
  endtask

  // One clock: predict, check at negedge, advance the model at posedge, then pick the next host request
  task automatic step(input bit p, input int h, input int v);
    bit act, fs, rd, rdy, fire, inr;
    int addr;
    pix_en = p; count_rgb = 11'(h); reset_count_rgb = 10'(v);
    act  = p && h < H && v < V;
    fs   = p && h == 0 && v == 0;
    rd   = act && (fs || scanning);
    addr = fs ? 0 : ((k > P - 1) ? P - 1 : k);
    rdy  = !rd;
`ifdef FB_VBLANK_ONLY_EN
    rdy  = rdy && !scanning;
`endif
    fire = wr_valid && rdy;
    inr  = int'(wr_addr) < P;
    @(negedge clk);
    obs_addr = int'(ram_addr); obs_ready = int'(wr_ready); obs_we = int'(ram_we);
    if (frame_start) fs_count++;
    check_eq("wr_ready", obs_ready, int'(rdy));
    check_eq("ram_we", obs_we, int'(fire && inr));
    if (rd) check_eq("rd_addr", obs_addr, addr);
    if (fire) check_eq("wr_addr_out", obs_addr, int'(wr_addr));
    if (fire && inr) check_eq("ram_wdata", int'(ram_wdata), int'(wr_data));
    check_eq("pixel", int'({red_1, green_1, blue_1}), exp_col);
    check_eq("frame_start", int'(frame_start), int'(exp_fs));
    check_eq("wr_err", int'(wr_err), int'(exp_err));
    @(posedge clk);
    if (p1_pe) exp_col = p1_rd ? p1_pix : 0;
    p1_pe  = p;
    p1_rd  = rd;
    p1_pix = rd ? ref_mem[addr] : 0;
    exp_fs = fs;
    if (fire && !inr) exp_err = 1;
    if (fire && inr) ref_mem[wr_addr] = int'(wr_data);
    if (rd) k = fs ? 1 : k + 1;
    if (p) begin
      if (fs) scanning = 1;
      else if (v >= V) scanning = 0;
    end
    #1;
    if (host_rand) begin
      if (!wr_valid || fire) begin
        wr_valid = 1'($urandom_range(0, 1));
        if (oor_ok && $urandom_range(0, 15) == 0) wr_addr = AW'(P + $urandom_range(0, 3));
        else wr_addr = AW'($urandom_range(0, P - 1));
        wr_data = PW'($urandom);
      end
    end else if (fire) begin
      wr_valid = 1'b0;
    end
  endtask

  task automatic pixel(input int h, input int v);
    step(1'b1, h, v);
    pix_addr = obs_addr;
    step(1'b0, h, v);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; fs_count = 0;
    host_rand = 0; oor_ok = 0;
    for (int i = 0; i < P; i++) ref_mem[i] = i % 64;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pixel", int'({red_1, green_1, blue_1}), 0);
    check_eq("rst_frame_start", int'(frame_start), 0);
    check_eq("rst_wr_err", int'(wr_err), 0);
    rst_n = 1'b1;

    // Mark pixel 0 so the first scan-out pixel is distinguishable from blanking
    wr_valid = 1'b1; wr_addr = '0; wr_data = 6'd45;
    step(1'b0, 0, 0);
    host_rand = 1;

    // First frame start: read address 0, colour RAM[0] two clocks later
    fs_count = 0;
    pixel(0, 0);
    check_eq("first_addr", pix_addr, 0);
    check_eq("first_pix", int'({red_1, green_1, blue_1}), 45);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (h == 0 && v == 0) continue;
        pixel(h, v);
        if (h == H - 1 && v == V - 1) check_eq("last_addr", pix_addr, P - 1);
      end
    end
    check_eq("fs_pulses", fs_count, 1);

    // Second frame restarts at 0, then reset in the middle of a line
    pixel(0, 0);
    check_eq("restart_addr", pix_addr, 0);
    for (int v = 0; v <= V / 2; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (h == 0 && v == 0) continue;
        if (v == V / 2 && h >= H / 2) break;
        pixel(h, v);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_pixel", int'({red_1, green_1, blue_1}), 0);
    check_eq("midrst_frame_start", int'(frame_start), 0);
    check_eq("midrst_wr_err", int'(wr_err), 0);
    model_reset();
    #1 rst_n = 1'b1;
    for (int v = V / 2; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (v == V / 2 && h < H / 2) continue;
        pixel(h, v);
      end
    end
    pixel(0, 0);
    check_eq("post_rst_addr", pix_addr, 0);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (h == 0 && v == 0) continue;
        pixel(h, v);
      end
    end

    // Out-of-range host write during vertical blanking
    host_rand = 0;
    for (int i = 0; i < 20 && wr_valid; i++) step(1'b0, 5, V + 1);
    wr_valid = 1'b1; wr_addr = AW'(P); wr_data = 6'd7;
    step(1'b0, 5, V + 1);
    check_eq("oor_ready", obs_ready, 1);
    check_eq("oor_we", obs_we, 0);
    step(1'b0, 5, V + 1);
    check_eq("oor_err", int'(wr_err), 1);

    // Overlong frame without blanking: address must pin at the last pixel
    host_rand = 1;
    pixel(0, 0);
    for (int i = 1; i < P + 10; i++) pixel(i % H, 1 + (i / H) % (V - 1));
    check_eq("sat_addr", pix_addr, P - 1);
    check_eq("err_sticky", int'(wr_err), 1);

    // Random counters, strobes and host traffic including out-of-range addresses
    oor_ok = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) step(1'($urandom_range(0, 1)), 0, 0);
      else step(1'($urandom_range(0, 1)), $urandom_range(0, H + 3), $urandom_range(0, V + 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
